dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and owns a word-organised synchronous SRAM. Sub-word stores are performed as read-modify-write, and load data is sign- or zero-extended before it is returned. It replaces the core's zero-latency combinational dmem model with a multi-cycle target, in preparation for pipelining.

Parameters:
BASE_ADDR, 32'h0100_0000, byte address of word 0
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2
AW, $clog2(DEPTH_WORDS), word-index width (derived)

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  32  byte address
req_write  in  1  1 = store, 0 = load
req_wdata  in  32  store data, right-aligned
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_error  out  1  request rejected

Behaviour:
- States are IDLE, RD, EXT, WR and RESP. Only one request is outstanding at a time.
- req_ready is 1 only in IDLE. A request is accepted on any edge where req_valid and req_ready are both 1. On acceptance the address, size, data, write and unsigned fields are latched.
- Error check happens at acceptance. Any of the following sends the request to RESP with rsp_error=1 and rsp_rdata=0, and memory is not touched:
  - size = 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - (addr - BASE_ADDR) >= DEPTH_WORDS*4, using unsigned 32-bit subtraction, so addresses below the base wrap and fail.
- Word index = (addr - BASE_ADDR)[AW+1:2]. Byte lane = addr[1:0]. Ordering is little-endian.
- Paths, with acceptance at edge T:
  - Load: RD (SRAM read enabled), then EXT (the SRAM data is lane-selected, extended and registered into rsp_rdata), then RESP. rsp_valid first rises after edge T+3.
  - Store word: WR (full-word write), then RESP. rsp_valid rises after edge T+2.
  - Store byte/half: RD, then EXT (the read word is merged with the new byte/half lanes and registered), then WR (merged word written), then RESP. rsp_valid rises after edge T+4.
  - Error: RESP directly. rsp_valid rises after edge T+1.
- RESP: rsp_valid=1. rsp_rdata and rsp_error are held stable until an edge where rsp_ready=1, after which the state returns to IDLE. The next request cannot be accepted earlier than the cycle after that edge.
- The SRAM is written only in WR. Its read has 1-cycle registered latency. No read-during-write case can occur.
- Reset (any state, including mid-RMW):
  - Next state is IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - req_ready=0 while reset is high.
  - An SRAM write enable in a cycle with reset high is suppressed.
  - SRAM contents are not cleared.
- Outputs are all registered or decoded from state only. There is no combinational path from req_* or rsp_ready to any output.

Decomposition:
- Shared package dmem_pkg holds:
  - Size codes: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
  - State enum: IDLE/RD/EXT/WR/RESP.
  - Lane-extract function (lane, size, unsigned -> 32 bits).
  - Lane-merge function (old word, new data, lane, size -> 32 bits).
- Sub-module word_sram: single port with clock, en, we, addr[AW-1:0], wdata[31:0], rdata[31:0]. rdata is registered on en & !we. No reset on the array.

Test Plan:
1. Store word 0xDEADBEEF to 0x0100_0010, then load word from the same address.
   - Store: rsp_valid two cycles after acceptance, rdata=0.
   - Load: rdata=0xDEADBEEF, error=0, rsp_valid three cycles after acceptance.
2. Store byte 0x5A to 0x0100_0011.
   - Load word gives 0xDEAD5AEF.
   - Signed load byte at 0x0100_0013 gives 0xFFFFFFDE.
   - Unsigned load byte at the same address gives 0x000000DE.
   - The sub-word store's response arrives four cycles after acceptance.
3. Store half 0x8234 to 0x0100_0012.
   - Load word gives 0x82345AEF.
   - Signed load half gives 0xFFFF8234.
   - Unsigned load half gives 0x00008234.
4. Error requests, each responding one cycle after acceptance with error=1 and rdata=0; a load word at 0x0100_0010 afterwards still returns 0x82345AEF:
   - Load word at 0x0100_0012 (misaligned).
   - Store at 0x0100_1000 (out of range).
   - Load at 0x00FF_FFFC (below base).
   - size=11.
5. Backpressure: hold rsp_ready=0 for 5 cycles during RESP.
   - rsp_valid, rsp_rdata and rsp_error stay stable.
   - req_ready stays 0 throughout.
   - Exactly one handshake completes when rsp_ready rises.
6. Assert reset for one cycle while in WR of a byte store of 0x00 to 0x0100_0010.
   - Next cycle: all outputs are at reset values and req_ready=0.
   - After reset: load word returns 0x82345AEF, i.e. the write was suppressed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared size codes, FSM states and byte-lane helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, RESP} state_t;

  // Pull the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      SIZE_H:  result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      default: result = word;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SIZE_B:  mask = 32'h0000_00FF;
      SIZE_H:  mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {lane, 3'b000};
    data = new_data << {lane, 3'b000};
    return (old_word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/word_sram.sv
// Single-port 32-bit word SRAM with one cycle of registered read latency.
// The array itself has no reset, matching a real macro.
module word_sram #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, sub-word stores
// done as read-modify-write, loads lane-selected and extended before return.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] index_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic          unsigned_q;
  logic [31:0]   wr_word_q;
  logic [31:0]   offset;
  logic [31:0]   sram_rdata;
  logic          accept;
  logic          req_err;
  logic          sram_en;
  logic          sram_we;

  assign offset    = req_addr - BASE_ADDR;
  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  // Addresses below the base wrap to a huge offset and fail the range test.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_B:  req_err = 1'b0;
      SIZE_H:  req_err = req_addr[0];
      SIZE_W:  req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (offset >= SPAN_BYTES) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sram_en = 1'b0;
    sram_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (req_write && req_size == SIZE_W) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        sram_en = 1'b1;
        state_d = EXT;
      end
      EXT: state_d = write_q ? WR : RESP;
      WR: begin
        sram_en = !reset;
        sram_we = !reset;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_rdata <= '0;
        rsp_error <= req_err;
      end else if (state_q == EXT && !write_q) begin
        rsp_rdata <= lane_extract(sram_rdata, lane_q, size_q, unsigned_q);
      end
    end
  end

  // Request fields are only consumed after an acceptance, so they need no reset.
  // wr_word_q holds the store data and is later overwritten by the merged word.
  always_ff @(posedge clock) begin
    if (accept) begin
      index_q    <= offset[AW+1:2];
      lane_q     <= req_addr[1:0];
      size_q     <= req_size;
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      wr_word_q  <= req_wdata;
    end else if (state_q == EXT && write_q) begin
      wr_word_q <= lane_merge(sram_rdata, wr_word_q, lane_q, size_q);
    end
  end

  word_sram #(.AW(AW)) u_sram (
    .clock (clock),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (index_q),
    .wdata (wr_word_q),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_b [4096];

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } op_t;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  function automatic op_t mk_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [1:0] s, input logic u, input logic [31:0] er,
                                input logic ee, input int el);
    op_t o;
    o.addr = a; o.write = w; o.wdata = d; o.size = s; o.uns = u;
    o.exp_rdata = er; o.exp_err = ee; o.exp_lat = el;
    return o;
  endfunction

  // Byte-level memory model: bytes live at (addr - BASE), little-endian.
  function automatic void model_access(input logic [31:0] addr, input logic wr,
                                       input logic [31:0] wd, input logic [1:0] sz,
                                       input logic uns, output logic [31:0] rd,
                                       output logic err, output int lat);
    logic [31:0] off;
    int nbytes;
    off    = addr - BASE;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err    = (sz == 2'd3) || ((addr % nbytes) != 0) || (off >= 32'd4096);
    rd     = '0;
    lat    = 0;
    if (err) begin
      lat = 1;
    end else if (wr) begin
      for (int i = 0; i < nbytes; i++) mem_b[int'(off) + i] = wd[8*i +: 8];
      lat = (nbytes == 4) ? 2 : 4;
    end else begin
      for (int i = 0; i < nbytes; i++) rd = rd | (32'(mem_b[int'(off) + i]) << (8*i));
      if (!uns && nbytes < 4 && rd[8*nbytes-1]) rd = rd | (32'hFFFF_FFFF << (8*nbytes));
      lat = 3;
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] s, input logic u, output logic ok);
    int n;
    @(negedge clock);
    req_addr = a; req_write = w; req_wdata = d; req_size = s; req_unsigned = u;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = req_ready;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic await_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic transact(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [1:0] s, input logic u, output logic [31:0] rd,
                          output logic err, output int lat);
    logic ok;
    issue(a, w, d, s, u, ok);
    if (!ok) begin
      rd = 'x; err = 1'bx; lat = -1;
    end else begin
      await_rsp(lat);
      rd  = rsp_rdata;
      err = rsp_error;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b exp=0", rsp_error); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_store_load;
    op_t ops[$];
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat, mlat;
    ops.push_back(mk_op(BASE + 32'h10, 1, 32'hDEAD_BEEF, 2'd2, 0, 32'h0, 0, 2));
    ops.push_back(mk_op(BASE + 32'h10, 0, 32'h0, 2'd2, 0, 32'hDEAD_BEEF, 0, 3));
    ops.push_back(mk_op(BASE + 32'h11, 1, 32'h0000_005A, 2'd0, 0, 32'h0, 0, 4));
    ops.push_back(mk_op(BASE + 32'h10, 0, 32'h0, 2'd2, 0, 32'hDEAD_5AEF, 0, 3));
    ops.push_back(mk_op(BASE + 32'h13, 0, 32'h0, 2'd0, 0, 32'hFFFF_FFDE, 0, 3));
    ops.push_back(mk_op(BASE + 32'h13, 0, 32'h0, 2'd0, 1, 32'h0000_00DE, 0, 3));
    ops.push_back(mk_op(BASE + 32'h12, 1, 32'h0000_8234, 2'd1, 0, 32'h0, 0, 4));
    ops.push_back(mk_op(BASE + 32'h10, 0, 32'h0, 2'd2, 0, 32'h8234_5AEF, 0, 3));
    ops.push_back(mk_op(BASE + 32'h12, 0, 32'h0, 2'd1, 0, 32'hFFFF_8234, 0, 3));
    ops.push_back(mk_op(BASE + 32'h12, 0, 32'h0, 2'd1, 1, 32'h0000_8234, 0, 3));
    foreach (ops[i]) begin
      model_access(ops[i].addr, ops[i].write, ops[i].wdata, ops[i].size, ops[i].uns, mrd, merr, mlat);
      transact(ops[i].addr, ops[i].write, ops[i].wdata, ops[i].size, ops[i].uns, rd, err, lat);
      checks++; if (rd !== ops[i].exp_rdata) begin failures++; $display("FAIL store_load[%0d] rdata got=%h exp=%h", i, rd, ops[i].exp_rdata); end
      checks++; if (err !== ops[i].exp_err) begin failures++; $display("FAIL store_load[%0d] error got=%b exp=%b", i, err, ops[i].exp_err); end
      checks++; if (lat !== ops[i].exp_lat) begin failures++; $display("FAIL store_load[%0d] latency got=%0d exp=%0d", i, lat, ops[i].exp_lat); end
    end
  endtask

  task automatic test_errors;
    op_t ops[$];
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat, mlat;
    ops.push_back(mk_op(BASE + 32'h12, 0, 32'h0, 2'd2, 0, 32'h0, 1, 1));
    ops.push_back(mk_op(32'h0100_1000, 1, 32'h1111_1111, 2'd2, 0, 32'h0, 1, 1));
    ops.push_back(mk_op(32'h00FF_FFFC, 0, 32'h0, 2'd2, 0, 32'h0, 1, 1));
    ops.push_back(mk_op(BASE + 32'h10, 0, 32'h0, 2'd3, 0, 32'h0, 1, 1));
    ops.push_back(mk_op(BASE + 32'h10, 0, 32'h0, 2'd2, 0, 32'h8234_5AEF, 0, 3));
    ops.push_back(mk_op(32'h0100_0FFC, 1, 32'h1234_5678, 2'd2, 0, 32'h0, 0, 2));
    ops.push_back(mk_op(32'h0100_0FFC, 0, 32'h0, 2'd2, 0, 32'h1234_5678, 0, 3));
    foreach (ops[i]) begin
      model_access(ops[i].addr, ops[i].write, ops[i].wdata, ops[i].size, ops[i].uns, mrd, merr, mlat);
      transact(ops[i].addr, ops[i].write, ops[i].wdata, ops[i].size, ops[i].uns, rd, err, lat);
      checks++; if (rd !== ops[i].exp_rdata) begin failures++; $display("FAIL errors[%0d] rdata got=%h exp=%h", i, rd, ops[i].exp_rdata); end
      checks++; if (err !== ops[i].exp_err) begin failures++; $display("FAIL errors[%0d] error got=%b exp=%b", i, err, ops[i].exp_err); end
      checks++; if (lat !== ops[i].exp_lat) begin failures++; $display("FAIL errors[%0d] latency got=%0d exp=%0d", i, lat, ops[i].exp_lat); end
    end
  endtask

  task automatic test_backpressure;
    logic ok;
    int lat;
    rsp_ready = 1'b0;
    issue(BASE + 32'h10, 1'b0, 32'h0, 2'd2, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL backpressure_accept got=%b exp=1", ok); end
    await_rsp(lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL backpressure_latency got=%0d exp=3", lat); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8234_5AEF || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] valid=%b rdata=%h err=%b req_ready=%b exp valid=1 rdata=82345aef err=0 req_ready=0",
                 c, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL backpressure_release valid=%b req_ready=%b exp valid=0 req_ready=1", rsp_valid, req_ready); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL backpressure_single got valid=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_mid_rmw;
    logic ok;
    logic [31:0] rd;
    logic err;
    int lat;
    issue(BASE + 32'h10, 1'b1, 32'h0, 2'd0, 1'b0, ok);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rmw_reset_req_ready_during got=%b exp=0", req_ready); end
    @(posedge clock);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmw_reset_outputs valid=%b rdata=%h err=%b req_ready=%b exp all 0",
               rsp_valid, rsp_rdata, rsp_error, req_ready);
    end
    reset = 1'b0;
    transact(BASE + 32'h10, 1'b0, 32'h0, 2'd2, 1'b0, rd, err, lat);
    checks++; if (rd !== 32'h8234_5AEF) begin failures++; $display("FAIL rmw_reset_suppressed rdata got=%h exp=82345aef", rd); end
    checks++; if (err !== 1'b0 || lat !== 3) begin failures++; $display("FAIL rmw_reset_load err=%b lat=%0d exp err=0 lat=3", err, lat); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, erd;
    logic [1:0] sz;
    logic w, u, err, eerr;
    int lat, elat, pick;
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      a = BASE + 32'h100 + 32'(4 * k);
      model_access(a, 1'b1, d, 2'd2, 1'b0, erd, eerr, elat);
      transact(a, 1'b1, d, 2'd2, 1'b0, rd, err, lat);
      checks++; if (lat !== elat || err !== eerr) begin failures++; $display("FAIL fill[%0d] lat=%0d err=%b exp lat=%0d err=%b", k, lat, err, elat, eerr); end
    end
    for (int k = 0; k < 60; k++) begin
      pick = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      u    = 1'($urandom_range(0, 1));
      d    = $urandom;
      a    = BASE + 32'h100 + 32'($urandom_range(0, 63));
      if (pick < 6 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      else if (pick == 8) a = 32'h0200_0000 | 32'($urandom);
      else if (pick == 9) a = 32'($urandom_range(0, 32'h00FF_FFFF));
      model_access(a, w, d, sz, u, erd, eerr, elat);
      transact(a, w, d, sz, u, rd, err, lat);
      checks++; if (rd !== erd) begin failures++; $display("FAIL random[%0d] rdata addr=%h sz=%0d w=%b got=%h exp=%h", k, a, sz, w, rd, erd); end
      checks++; if (err !== eerr) begin failures++; $display("FAIL random[%0d] error addr=%h sz=%0d got=%b exp=%b", k, a, sz, err, eerr); end
      checks++; if (lat !== elat) begin failures++; $display("FAIL random[%0d] latency addr=%h sz=%0d w=%b got=%0d exp=%0d", k, a, sz, w, lat, elat); end
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_write    = 1'b0;
    req_wdata    = '0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
